viterbi_frame_ctrl: RTL

Frame sequencer sitting in front of viterbi_decoder (ports d, cx[1:0], clk, reset). Each frame it resets the decoder, streams FRAME_LEN 2-bit encoded symbols into cx, then streams DEC_LAT zero tail symbols to flush the decoder. It captures the FRAME_LEN decoded bits from d into a parallel word and hands that word to a downstream consumer with a valid/ready handshake. The decoder has no stall input, so this block owns all pacing and underrun handling.

---
 rtl/viterbi_frame_ctrl_if.sv | 22 ++
 rtl/viterbi_frame_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_ctrl_if.sv
// Symbol-in / word-out handshake bundle for viterbi_frame_ctrl.
// The master side drives symbols and accepts words; the slave side is the controller.
interface viterbi_frame_ctrl_if #(
  parameter int FRAME_LEN = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_sym;
  logic                 out_valid;
  logic                 out_ready;
  logic [FRAME_LEN-1:0] out_data;

  modport master (
    output in_valid, in_sym, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sym, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer in front of viterbi_decoder: reset it, feed a frame, flush, hand off the word.
// Optional build macro VITERBI_FRAME_CTRL_STATS_EN adds frame and underrun counters.
//
// state | meaning
// IDLE  | waiting for in_valid to open a frame
// RST   | one-cycle decoder reset
// FEED  | FRAME_LEN symbol slots, missing symbols replaced by zeros
// FLUSH | DEC_LAT zero tail symbols while the last bits drain
// DONE  | word presented until out_ready
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int DEC_LAT   = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  viterbi_frame_ctrl_if.slave bus,
  output logic                dec_reset_o,
  output logic [1:0]          dec_cx_o,
  input  logic                dec_d_i,
  output logic                busy_o,
  output logic                underrun_o
`ifdef VITERBI_FRAME_CTRL_STATS_EN
  ,
  output logic [15:0]         frame_cnt_o,
  output logic [15:0]         underrun_cnt_o
`endif
);

  localparam int SW = $clog2(FRAME_LEN + 1);
  localparam int LW = $clog2(DEC_LAT + 1);

  typedef enum logic [2:0] {IDLE, RST, FEED, FLUSH, DONE} state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        sym_cnt_q, sym_cnt_d;
  logic [SW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]        lat_cnt_q, lat_cnt_d;
  logic [DEC_LAT-1:0]   tag_q, tag_d;
  logic                 tag_in;
  logic [FRAME_LEN-1:0] out_data_q, out_data_d;
  logic [1:0]           dec_cx_q, dec_cx_d;
  logic                 underrun_q, underrun_d;

  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    dec_cx_d   = 2'b00;
    underrun_d = underrun_q;
    tag_in     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d    = RST;
          underrun_d = 1'b0;
        end
      end
      RST: begin
        sym_cnt_d = '0;
        state_d   = FEED;
      end
      FEED: begin
        tag_in = 1'b1;
        // A missing symbol still uses its slot so the decoder timing never stretches.
        if (bus.in_valid) dec_cx_d = bus.in_sym;
        else underrun_d = 1'b1;
        if (sym_cnt_q == SW'(FRAME_LEN - 1)) begin
          sym_cnt_d = '0;
          lat_cnt_d = LW'(DEC_LAT - 1);
          state_d   = FLUSH;
        end else begin
          sym_cnt_d = sym_cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (lat_cnt_q == '0) state_d = DONE;
        else lat_cnt_d = lat_cnt_q - 1'b1;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag marks which decoder output cycles carry a frame bit.
  if (DEC_LAT == 1) begin : g_tag_1
    assign tag_d = tag_in;
  end else begin : g_tag_n
    assign tag_d = {tag_q[DEC_LAT-2:0], tag_in};
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    out_data_d = out_data_q;
    if (state_q == RST) begin
      bit_cnt_d  = '0;
      out_data_d = '0;
    end else if (tag_q[DEC_LAT-1]) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        if (bit_cnt_q == SW'(k)) out_data_d[k] = dec_d_i;
      end
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      sym_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      lat_cnt_q  <= '0;
      tag_q      <= '0;
      out_data_q <= '0;
      dec_cx_q   <= 2'b00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      tag_q      <= tag_d;
      out_data_q <= out_data_d;
      dec_cx_q   <= dec_cx_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.in_ready  = (state_q == FEED);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign dec_reset_o   = reset_i || (state_q == RST);
  assign dec_cx_o      = dec_cx_q;
  assign busy_o        = (state_q != IDLE);
  assign underrun_o    = underrun_q;

`ifdef VITERBI_FRAME_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((state_q == FEED) && !bus.in_valid && (underrun_cnt_q != 16'hFFFF))
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_o    = frame_cnt_q;
  assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule
